// File: rtl/lab1_imul_resp_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab1_imul_resp_accum_pkg
// Purpose  : Shared types and default widths for the multiplier response
//            accumulator (control/status bundles between ctrl and dpath).
// Contents : c_NBITS, c_LEN_NBITS        - default product/sum and length widths
//            lab1_imul_resp_accum_cs_t   - control signals ctrl -> dpath
//            lab1_imul_resp_accum_ss_t   - status signals  dpath -> ctrl
// Revision : 1.0 - initial release
// ============================================================================
package lab1_imul_resp_accum_pkg;

  localparam int c_NBITS     = 32;
  localparam int c_LEN_NBITS = 8;

  typedef struct packed {
    logic sum_clr;      // zero the running sum
    logic sum_en;       // add the accepted product into the sum
    logic remain_load;  // load the run length from cfg_len
    logic remain_dec;   // one product consumed
  } lab1_imul_resp_accum_cs_t;

  typedef struct packed {
    logic remain_is_one;  // the product being accepted is the last of the run
    logic len_is_zero;    // the offered run length is empty
  } lab1_imul_resp_accum_ss_t;

endpackage
`default_nettype wire

// File: rtl/lab1_imul_resp_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lab1_imul_resp_accum_ctrl
// Purpose  : Control unit of the response accumulator. Three-state Moore
//            machine (IDLE -> ACCUM -> DONE -> IDLE); all ready/valid
//            outputs depend only on the current state.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            i_cfg_val/o_cfg_rdy - run-length config handshake
//            i_in_val/o_in_rdy   - product handshake
//            o_out_val/i_out_rdy - sum handshake
//            o_cs / i_ss         - control to / status from the datapath
// Revision : 1.0 - initial release
// ============================================================================
module lab1_imul_resp_accum_ctrl
  import lab1_imul_resp_accum_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cfg_val,
  output logic                     o_cfg_rdy,
  input  logic                     i_in_val,
  output logic                     o_in_rdy,
  output logic                     o_out_val,
  input  logic                     i_out_rdy,
  output lab1_imul_resp_accum_cs_t o_cs,
  input  lab1_imul_resp_accum_ss_t i_ss
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_cfg_go;
  logic   w_in_go;
  logic   w_out_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake "go" terms use the Moore ready/valid outputs, so they never
  // feed back into those outputs.
  assign w_cfg_go = i_cfg_val && o_cfg_rdy;
  assign w_in_go  = i_in_val  && o_in_rdy;
  assign w_out_go = o_out_val && i_out_rdy;

  always_comb begin
    w_state_next     = r_state;
    o_cfg_rdy        = 1'b0;
    o_in_rdy         = 1'b0;
    o_out_val        = 1'b0;
    o_cs.sum_clr     = 1'b0;
    o_cs.sum_en      = 1'b0;
    o_cs.remain_load = 1'b0;
    o_cs.remain_dec  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        o_cfg_rdy        = 1'b1;
        o_cs.sum_clr     = w_cfg_go;
        o_cs.remain_load = w_cfg_go;
        if (w_cfg_go) begin
          // An empty run goes straight to DONE and reports a zero sum.
          w_state_next = i_ss.len_is_zero ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        o_in_rdy        = 1'b1;
        o_cs.sum_en     = w_in_go;
        o_cs.remain_dec = w_in_go;
        if (w_in_go && i_ss.remain_is_one) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_out_val = 1'b1;
        // Always return through IDLE: no config is taken in the same cycle
        // the sum leaves.
        if (w_out_go) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lab1_imul_resp_accum_dpath.sv
`default_nettype none
// ============================================================================
// Module   : lab1_imul_resp_accum_dpath
// Purpose  : Datapath of the response accumulator: running sum register,
//            remaining-count register, wrapping adder and (optionally) a
//            sticky carry-out flag.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            i_cs               - control bundle from the control unit
//            o_ss               - status bundle to the control unit
//            i_cfg_len          - run length offered on the config port
//            i_in_msg           - product offered on the input port
//            o_out_msg          - current running sum
//            o_out_ovf          - sticky carry flag (LAB1_IMUL_RESP_ACCUM_OVF_EN)
// Macro    : LAB1_IMUL_RESP_ACCUM_OVF_EN adds the carry flag register/port.
// Revision : 1.0 - initial release
// ============================================================================
module lab1_imul_resp_accum_dpath
  import lab1_imul_resp_accum_pkg::*;
#(
  parameter int p_nbits     = c_NBITS,
  parameter int p_len_nbits = c_LEN_NBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  lab1_imul_resp_accum_cs_t i_cs,
  output lab1_imul_resp_accum_ss_t o_ss,
  input  logic [p_len_nbits-1:0]   i_cfg_len,
  input  logic [p_nbits-1:0]       i_in_msg,
`ifdef LAB1_IMUL_RESP_ACCUM_OVF_EN
  output logic                     o_out_ovf,
`endif
  output logic [p_nbits-1:0]       o_out_msg
);

  localparam logic [p_len_nbits-1:0] c_ONE = p_len_nbits'(1);

  logic [p_nbits-1:0]     r_sum;
  logic [p_len_nbits-1:0] r_remain;
  logic [p_nbits-1:0]     w_sum_next;

`ifdef LAB1_IMUL_RESP_ACCUM_OVF_EN
  logic w_carry;
  logic r_ovf;

  // One extra bit captures the carry out of the p_nbits-wide add.
  assign {w_carry, w_sum_next} = {1'b0, r_sum} + {1'b0, i_in_msg};

  always_ff @(posedge clk) begin
    if (reset || i_cs.sum_clr) begin
      r_ovf <= 1'b0;
    end else if (i_cs.sum_en && w_carry) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_out_ovf = r_ovf;
`else
  // Sum wraps modulo 2^p_nbits; the carry is simply dropped.
  assign w_sum_next = r_sum + i_in_msg;
`endif

  always_ff @(posedge clk) begin
    if (reset || i_cs.sum_clr) begin
      r_sum <= '0;
    end else if (i_cs.sum_en) begin
      r_sum <= w_sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain <= '0;
    end else if (i_cs.remain_load) begin
      r_remain <= i_cfg_len;
    end else if (i_cs.remain_dec) begin
      r_remain <= r_remain - c_ONE;
    end
  end

  assign o_ss.remain_is_one = (r_remain == c_ONE);
  assign o_ss.len_is_zero   = (i_cfg_len == '0);
  assign o_out_msg          = r_sum;

endmodule
`default_nettype wire

// File: rtl/lab1_imul_resp_accum.sv
`default_nettype none
// ============================================================================
// Module   : lab1_imul_resp_accum
// Purpose  : Consumer of the integer multiplier's response stream. Accepts a
//            run length N on the config port, sums the next N products
//            (modulo 2^p_nbits) and emits one sum message.
// Ports    : clk, reset                - clock, synchronous active-high reset
//            cfg_val/cfg_rdy/cfg_len   - run-length config handshake
//            in_val/in_rdy/in_msg      - product stream (multiplier resp)
//            out_val/out_rdy/out_msg   - accumulated sum
//            out_ovf                   - sticky carry flag (optional)
// Macro    : LAB1_IMUL_RESP_ACCUM_OVF_EN - when defined, adds out_ovf, set if
//            any add of the run carried out of p_nbits bits.
// Revision : 1.0 - initial release
// ============================================================================
module lab1_imul_resp_accum
  import lab1_imul_resp_accum_pkg::*;
#(
  parameter int p_nbits     = c_NBITS,
  parameter int p_len_nbits = c_LEN_NBITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [p_len_nbits-1:0] cfg_len,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_nbits-1:0]     in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
`ifdef LAB1_IMUL_RESP_ACCUM_OVF_EN
  output logic                   out_ovf,
`endif
  output logic [p_nbits-1:0]     out_msg
);

  lab1_imul_resp_accum_cs_t w_cs;
  lab1_imul_resp_accum_ss_t w_ss;

  lab1_imul_resp_accum_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .i_cfg_val (cfg_val),
    .o_cfg_rdy (cfg_rdy),
    .i_in_val  (in_val),
    .o_in_rdy  (in_rdy),
    .o_out_val (out_val),
    .i_out_rdy (out_rdy),
    .o_cs      (w_cs),
    .i_ss      (w_ss)
  );

  lab1_imul_resp_accum_dpath #(
    .p_nbits     (p_nbits),
    .p_len_nbits (p_len_nbits)
  ) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .i_cs      (w_cs),
    .o_ss      (w_ss),
    .i_cfg_len (cfg_len),
    .i_in_msg  (in_msg),
`ifdef LAB1_IMUL_RESP_ACCUM_OVF_EN
    .o_out_ovf (out_ovf),
`endif
    .o_out_msg (out_msg)
  );

endmodule
`default_nettype wire
